// File: rtl/dct_pkg.sv
// -----------------------------------------------------------------------------
// dct_pkg
// Shared types and lifting helpers for the forward 8x8 binDCT.
//   COEF_W  : coefficient / internal datapath width (signed)
//   BLOCK_N : transform size (8)
//   coef_t  : one signed coefficient
//   row_t   : eight coefficients, element i = index i
//   q, p, r : shift-and-add lifting multipliers used by the 1-D transform
//             (q ~ 3/8, p ~ 5/8, r ~ 7/8; all shifts arithmetic, result wraps)
// -----------------------------------------------------------------------------
package dct_pkg;

    localparam int COEF_W  = 16;
    localparam int BLOCK_N = 8;

    typedef logic signed [COEF_W-1:0] coef_t;
    typedef coef_t [BLOCK_N-1:0]      row_t;

    // q(v) = v/8 + v/4
    function automatic coef_t q(input coef_t v);
        return (v >>> 32'd3) + (v >>> 32'd2);
    endfunction

    // p(v) = v/8 + v/2
    function automatic coef_t p(input coef_t v);
        return (v >>> 32'd3) + (v >>> 32'd1);
    endfunction

    // r(v) = q(v) + v/2
    function automatic coef_t r(input coef_t v);
        return q(v) + (v >>> 32'd1);
    endfunction

endpackage

// File: rtl/dct_ft_1d.sv
// -----------------------------------------------------------------------------
// dct_ft_1d
// Combinational 8-point forward binDCT (integer lifting). Every intermediate is
// a signed COEF_W value; overflow wraps, no saturation.
// Ports:
//   din  : input vector, element i = sample i
//   dout : output vector, element k = frequency k
// -----------------------------------------------------------------------------
module dct_ft_1d
    import dct_pkg::*;
(
    input  row_t din,
    output row_t dout
);

    coef_t x_s [8];
    coef_t a_s [8];
    coef_t d_s [8];
    coef_t y_s [8];
    coef_t a6p_s;
    coef_t a5p_s;

    // Butterfly: sums into the low half, differences into the high half
    for (genvar i = 0; i < 8; i++) begin : g_in
        assign x_s[i] = din[i];
    end

    for (genvar i = 0; i < 4; i++) begin : g_bfly
        assign a_s[i]     = x_s[i] + x_s[7-i];
        assign a_s[7-i]   = x_s[i] - x_s[7-i];
    end

    // Rotation of the (a5, a6) pair done as two lifting steps
    assign a6p_s = a_s[6] + q(a_s[5]);
    assign a5p_s = p(a6p_s) - a_s[5];

    assign d_s[0] = a_s[0] + a_s[3];
    assign d_s[3] = a_s[0] - a_s[3];
    assign d_s[1] = a_s[1] + a_s[2];
    assign d_s[2] = a_s[1] - a_s[2];
    assign d_s[4] = a_s[4] + a5p_s;
    assign d_s[5] = a_s[4] - a5p_s;
    assign d_s[6] = a_s[7] - a6p_s;
    assign d_s[7] = a6p_s + a_s[7];

    // Final lifting stage; y1, y3 and y6 depend on already-lifted outputs
    assign y_s[0] = d_s[0] + d_s[1];
    assign y_s[1] = (y_s[0] >>> 32'd1) - d_s[1];
    assign y_s[2] = d_s[2] - q(d_s[3]);
    assign y_s[3] = d_s[3] + q(y_s[2]);
    assign y_s[7] = d_s[7];
    assign y_s[4] = d_s[4] - (d_s[7] >>> 32'd3);
    assign y_s[5] = d_s[5] + r(d_s[6]);
    assign y_s[6] = d_s[6] - (y_s[5] >>> 32'd1);

    for (genvar k = 0; k < 8; k++) begin : g_out
        assign dout[k] = y_s[k];
    end

endmodule

// File: rtl/dct_ft_2d.sv
// -----------------------------------------------------------------------------
// dct_ft_2d
// Forward 8x8 2-D binDCT. Rows are transformed on arrival and written into one
// bank of a ping-pong buffer; once a bank holds 8 rows its columns are read,
// transformed and streamed out one column per accepted beat.
// Ports:
//   clk, rst         : single clock, synchronous active-high reset
//   s_valid/s_ready  : input row handshake
//   s_data           : pixel row, element i = column i
//   m_valid/m_ready  : output column handshake
//   m_data           : coefficient column j, element k = vertical frequency k
//   m_last           : marks column 7 of each block
// Configuration:
//   DCT_LEVEL_SHIFT_EN : pixels are unsigned and 2^(INPUT_W-1) is subtracted
//                        before the row pass; otherwise pixels are signed.
// -----------------------------------------------------------------------------
module dct_ft_2d
    import dct_pkg::*;
#(
    parameter int INPUT_W  = 8,
    parameter int OUTPUT_W = COEF_W
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic        [7:0][INPUT_W-1:0]     s_data,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic signed [7:0][OUTPUT_W-1:0]    m_data,
    output logic                               m_last
);

`ifdef DCT_LEVEL_SHIFT_EN
    localparam coef_t LVL_OFS = coef_t'(32'sd1 <<< (INPUT_W - 1));
`endif

    coef_t      buf_r [2][8][8];
    logic [1:0] full_r;
    logic [1:0] full_set_s;
    logic [1:0] full_clr_s;
    logic       wr_bank_r;
    logic       rd_bank_r;
    logic [2:0] row_cnt_r;
    logic [2:0] col_cnt_r;

    row_t       in_row_s;
    row_t       row_res_s;
    row_t       col_in_s;
    row_t       col_res_s;

    logic       wr_fire_s;
    logic       rd_fire_s;
    logic       wr_last_s;
    logic       rd_last_s;

    // Widen pixels to the coefficient width (with optional level shift)
    for (genvar i = 0; i < 8; i++) begin : g_pix
`ifdef DCT_LEVEL_SHIFT_EN
        assign in_row_s[i] = coef_t'({{(COEF_W-INPUT_W){1'b0}}, s_data[i]}) - LVL_OFS;
`else
        assign in_row_s[i] = coef_t'({{(COEF_W-INPUT_W){s_data[i][INPUT_W-1]}}, s_data[i]});
`endif
    end

    dct_ft_1d u_row_pass (
        .din  (in_row_s),
        .dout (row_res_s)
    );

    // Transposed read: column col_cnt of the bank being drained
    for (genvar k = 0; k < 8; k++) begin : g_col
        assign col_in_s[k] = buf_r[rd_bank_r][k][col_cnt_r];
    end

    dct_ft_1d u_col_pass (
        .din  (col_in_s),
        .dout (col_res_s)
    );

    assign s_ready   = ~full_r[wr_bank_r] & ~rst;
    assign wr_fire_s = s_valid & s_ready;
    assign rd_fire_s = full_r[rd_bank_r] & (~m_valid | m_ready);
    assign wr_last_s = wr_fire_s & (row_cnt_r == 3'd7);
    assign rd_last_s = rd_fire_s & (col_cnt_r == 3'd7);

    // Fill and drain always touch different banks, so set and clear never collide
    assign full_set_s = {wr_last_s & wr_bank_r, wr_last_s & ~wr_bank_r};
    assign full_clr_s = {rd_last_s & rd_bank_r, rd_last_s & ~rd_bank_r};

    // Transpose buffer write: one transformed row per accepted input beat
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            for (int c = 0; c < 8; c++) begin
                buf_r[wr_bank_r][row_cnt_r][c] <= row_res_s[c];
            end
        end
    end

    // Bank bookkeeping, counters and the registered output column
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r    <= 2'b00;
            wr_bank_r <= 1'b0;
            rd_bank_r <= 1'b0;
            row_cnt_r <= 3'd0;
            col_cnt_r <= 3'd0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            m_data    <= '0;
        end else begin
            full_r <= (full_r | full_set_s) & ~full_clr_s;

            if (wr_fire_s) begin
                row_cnt_r <= row_cnt_r + 3'd1;
                if (wr_last_s) begin
                    wr_bank_r <= ~wr_bank_r;
                end
            end

            if (rd_fire_s) begin
                m_data    <= col_res_s;
                m_valid   <= 1'b1;
                m_last    <= rd_last_s;
                col_cnt_r <= col_cnt_r + 3'd1;
                if (rd_last_s) begin
                    rd_bank_r <= ~rd_bank_r;
                end
            end else if (m_ready) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
        end
    end

endmodule
